// File: rtl/sobel_frame_ctrl.sv
// Frame controller for a streaming 3x3 Sobel engine.
//
// Walks the image in horizontal bands of three rows. For each band the engine is
// reset, fed nine pixels (the first three columns, column-major), then one new
// column of three pixels per result. Reads are issued one cycle ahead of engine
// consumption, and each engine result is written to the edge memory at
// r*(W-2)+k, where k counts results within the band.
//
// Ports:
//   clk_i        clock, all state changes on the rising edge
//   rstn_i       synchronous active-low reset
//   start_i      frame start request, honoured only while idle
//   thr_i        edge threshold, captured on an accepted start
//   busy_o       high from accepted start until the frame completes
//   done_o       one-cycle pulse at frame completion
//   rd_en_o      pixel memory read strobe
//   rd_addr_o    pixel address, row*W + col
//   rd_data_i    pixel data, valid the cycle after rd_en_o
//   eng_rstn_o   synchronous active-low reset to the engine
//   eng_data_o   pixel to the engine (direct from rd_data_i)
//   eng_thr_o    captured threshold to the engine
//   eng_ready_i  engine result-valid pulse
//   eng_bit_i    engine edge result
//   wr_en_o      edge memory write strobe
//   wr_addr_o    edge address, r*(W-2) + k
//   wr_data_o    edge bit
module sobel_frame_ctrl #(
  parameter int unsigned H  = 200,
  parameter int unsigned W  = 160,
  parameter int unsigned AW = 16
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          start_i,
  input  logic [7:0]    thr_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  input  logic [7:0]    rd_data_i,
  output logic          eng_rstn_o,
  output logic [7:0]    eng_data_o,
  output logic [7:0]    eng_thr_o,
  input  logic          eng_ready_i,
  input  logic          eng_bit_i,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          wr_data_o
);

  localparam int unsigned RW = $clog2(H);      // band index 0..H-3
  localparam int unsigned CW = $clog2(W + 1);  // read column 0..W
  localparam int unsigned KW = $clog2(W);      // result index 0..W-2

  localparam logic [RW-1:0] LastBand = RW'(H - 3);
  localparam logic [CW-1:0] NumCols  = CW'(W);
  localparam logic [AW-1:0] RowStep  = AW'(W);
  localparam logic [AW-1:0] ColBack  = AW'(2 * W - 1);
  localparam logic [AW-1:0] WrStep   = AW'(W - 2);

  typedef enum logic [2:0] {
    StIdle,
    StBandRst,
    StLoad,
    StGap,
    StShift,
    StDrain,
    StFin
  } state_e;

  state_e        state_q;
  logic [3:0]    cyc_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] rd_col_q;
  logic [1:0]    rd_row_q;
  logic [KW-1:0] k_q;
  logic [AW-1:0] band_base_q;
  logic [AW-1:0] wr_base_q;
  logic [AW-1:0] rd_addr_q;
  logic [7:0]    thr_q;
  logic          busy_q;
  logic          done_q;
  logic          rd_en_q;
  logic          eng_rstn_q;
  logic          wr_en;

  // Results arrive in the same cycle they must be written; busy gates out strays.
  assign wr_en = eng_ready_i & busy_q;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= StIdle;
      cyc_q       <= '0;
      r_q         <= '0;
      rd_col_q    <= '0;
      rd_row_q    <= '0;
      k_q         <= '0;
      band_base_q <= '0;
      wr_base_q   <= '0;
      rd_addr_q   <= '0;
      thr_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      eng_rstn_q  <= 1'b0;
    end else begin
      // Read pointer walks rows r..r+2 of a column, then steps to the next column.
      if (rd_en_q) begin
        if (rd_row_q == 2'd2) begin
          rd_row_q  <= 2'd0;
          rd_col_q  <= rd_col_q + 1'b1;
          rd_addr_q <= rd_addr_q - ColBack;
        end else begin
          rd_row_q  <= rd_row_q + 2'd1;
          rd_addr_q <= rd_addr_q + RowStep;
        end
      end

      if (wr_en) begin
        k_q <= k_q + 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q     <= StBandRst;
            thr_q       <= thr_i;
            busy_q      <= 1'b1;
            r_q         <= '0;
            band_base_q <= '0;
            wr_base_q   <= '0;
            rd_addr_q   <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            k_q         <= '0;
            rd_en_q     <= 1'b1;
          end
        end
        StBandRst: begin
          state_q    <= StLoad;
          cyc_q      <= '0;
          eng_rstn_q <= 1'b1;
          rd_en_q    <= 1'b1;
        end
        StLoad: begin
          if (cyc_q == 4'd8) begin
            state_q <= StGap;
            rd_en_q <= (rd_col_q < NumCols);
          end else begin
            cyc_q   <= cyc_q + 4'd1;
            // No read in the last load cycle: the following cycle is a gap.
            rd_en_q <= (cyc_q < 4'd7);
          end
        end
        StGap: begin
          if (rd_col_q < NumCols) begin
            state_q <= StShift;
            cyc_q   <= '0;
            rd_en_q <= 1'b1;
          end else begin
            state_q <= StDrain;
            rd_en_q <= 1'b0;
          end
        end
        StShift: begin
          if (cyc_q == 4'd2) begin
            state_q <= StGap;
            rd_en_q <= (rd_col_q < NumCols);
          end else begin
            cyc_q   <= cyc_q + 4'd1;
            rd_en_q <= (cyc_q == 4'd0);
          end
        end
        StDrain: begin
          // The last result of the band lands in this cycle.
          if (r_q < LastBand) begin
            state_q     <= StBandRst;
            r_q         <= r_q + 1'b1;
            band_base_q <= band_base_q + RowStep;
            wr_base_q   <= wr_base_q + WrStep;
            rd_addr_q   <= band_base_q + RowStep;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            k_q         <= '0;
            eng_rstn_q  <= 1'b0;
            rd_en_q     <= 1'b1;
          end else begin
            state_q <= StFin;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rd_en_q <= 1'b0;
          end
        end
        StFin: begin
          state_q    <= StIdle;
          done_q     <= 1'b0;
          eng_rstn_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign rd_en_o    = rd_en_q;
  assign rd_addr_o  = rd_addr_q;
  assign eng_rstn_o = eng_rstn_q;
  assign eng_data_o = rd_data_i;
  assign eng_thr_o  = thr_q;
  assign wr_en_o    = wr_en;
  assign wr_addr_o  = wr_base_q + AW'(k_q);
  assign wr_data_o  = wr_en & eng_bit_i;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed bench for sobel_frame_ctrl: a 4x5 instance driven by a pixel memory
// and a behavioural Sobel engine, plus a 10x8 instance for geometry and timing.
module tb_sobel_frame_ctrl;

  localparam int SH = 4;
  localparam int SW = 5;
  localparam int BH = 10;
  localparam int BW = 8;

  logic clk;
  logic rstn;

  // Small instance
  logic       start;
  logic [7:0] thr;
  logic       busy, done, rd_en, eng_rstn, eng_ready, eng_bit, wr_en, wr_data;
  logic [7:0] rd_addr, wr_addr, rd_data, eng_data, eng_thr;

  // Larger instance
  logic        b_start, b_busy, b_done, b_rd_en, b_eng_rstn, b_ready, b_wr_en, b_wr_data;
  logic [15:0] b_rd_addr, b_wr_addr;
  logic [7:0]  b_eng_data, b_eng_thr;

  int n_checks = 0;
  int n_errors = 0;

  sobel_frame_ctrl #(.H(SH), .W(SW), .AW(8)) u_dut (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (start),
    .thr_i       (thr),
    .busy_o      (busy),
    .done_o      (done),
    .rd_en_o     (rd_en),
    .rd_addr_o   (rd_addr),
    .rd_data_i   (rd_data),
    .eng_rstn_o  (eng_rstn),
    .eng_data_o  (eng_data),
    .eng_thr_o   (eng_thr),
    .eng_ready_i (eng_ready),
    .eng_bit_i   (eng_bit),
    .wr_en_o     (wr_en),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  sobel_frame_ctrl #(.H(BH), .W(BW), .AW(16)) u_dut_big (
    .clk_i       (clk),
    .rstn_i      (rstn),
    .start_i     (b_start),
    .thr_i       (8'd5),
    .busy_o      (b_busy),
    .done_o      (b_done),
    .rd_en_o     (b_rd_en),
    .rd_addr_o   (b_rd_addr),
    .rd_data_i   (8'd0),
    .eng_rstn_o  (b_eng_rstn),
    .eng_data_o  (b_eng_data),
    .eng_thr_o   (b_eng_thr),
    .eng_ready_i (b_ready),
    .eng_bit_i   (1'b1),
    .wr_en_o     (b_wr_en),
    .wr_addr_o   (b_wr_addr),
    .wr_data_o   (b_wr_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Pixel memory: smooth horizontal ramp with some texture.
  logic [7:0] img [SH*SW];
  initial begin
    for (int i = 0; i < SH * SW; i++) begin
      img[i] = 8'(((i % SW) * 45 + (i / SW) * 17 + (i * 29) % 23) & 255);
    end
  end

  always @(posedge clk) begin
    if (rd_en) rd_data <= img[rd_addr];
  end

  function automatic int sobel(input int a0, a1, a2, b0, b1, b2, c0, c1, c2, input int t);
    int gx, gy;
    gx = (c0 + 2 * c1 + c2) - (a0 + 2 * a1 + a2);
    gy = (a2 + 2 * b2 + c2) - (a0 + 2 * b0 + c0);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    return (gx + gy > t) ? 1 : 0;
  endfunction

  function automatic int px(input int r, input int c);
    return int'(img[r * SW + c]);
  endfunction

  function automatic int ref_bit(input int r, input int k, input int t);
    return sobel(px(r, k), px(r + 1, k), px(r + 2, k),
                 px(r, k + 1), px(r + 1, k + 1), px(r + 2, k + 1),
                 px(r, k + 2), px(r + 1, k + 2), px(r + 2, k + 2), t);
  endfunction

  // Behavioural engine: 9 loads, gap, then 3 loads + gap per further column.
  logic [7:0] win [3][3];
  logic [7:0] nb [3];
  int         m_ph;
  logic       m_ready, m_bit, spur_rdy;

  always @(posedge clk) begin
    if (!eng_rstn) begin
      m_ph    <= 0;
      m_ready <= 1'b0;
    end else begin
      m_ph    <= m_ph + 1;
      m_ready <= 1'b0;
      if (m_ph < 9) begin
        win[m_ph % 3][m_ph / 3] <= eng_data;
      end else if ((m_ph - 9) % 4 == 0) begin
        m_ready <= 1'b1;
        if (m_ph == 9) begin
          m_bit <= sobel(win[0][0], win[1][0], win[2][0], win[0][1], win[1][1], win[2][1],
                         win[0][2], win[1][2], win[2][2], int'(eng_thr)) != 0;
        end else begin
          m_bit <= sobel(win[0][1], win[1][1], win[2][1], win[0][2], win[1][2], win[2][2],
                         nb[0], nb[1], nb[2], int'(eng_thr)) != 0;
          for (int i = 0; i < 3; i++) begin
            win[i][0] <= win[i][1];
            win[i][1] <= win[i][2];
            win[i][2] <= nb[i];
          end
        end
      end else begin
        nb[(m_ph - 10) % 4] <= eng_data;
      end
    end
  end

  assign eng_ready = m_ready | spur_rdy;
  assign eng_bit   = m_bit;

  // Timing-only engine for the larger instance.
  int   b_ph;
  logic b_rdy_q;
  always @(posedge clk) begin
    if (!b_eng_rstn) begin
      b_ph    <= 0;
      b_rdy_q <= 1'b0;
    end else begin
      b_ph    <= b_ph + 1;
      b_rdy_q <= (b_ph >= 9) && ((b_ph - 9) % 4 == 0);
    end
  end
  assign b_ready = b_rdy_q;

  int tot_wr = 0;
  always @(posedge clk) begin
    if (wr_en) tot_wr <= tot_wr + 1;
  end

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(done), 0);
    check_val({tag, "_rd_en"}, int'(rd_en), 0);
    check_val({tag, "_wr_en"}, int'(wr_en), 0);
    check_val({tag, "_eng_rstn"}, int'(eng_rstn), 0);
    check_val({tag, "_eng_thr"}, int'(eng_thr), 0);
    check_val({tag, "_rd_addr"}, int'(rd_addr), 0);
    check_val({tag, "_wr_addr"}, int'(wr_addr), 0);
    check_val({tag, "_wr_data"}, int'(wr_data), 0);
  endtask

  // Per-frame observations, cycle numbers relative to the start cycle (cycle 0).
  int wr_a[$], wr_d[$], rd_a[$];
  int last_wr, done_cyc, done_cnt, busy_first, busy_last, busy_cnt, thr_bad, overlap;

  task automatic run_frame(input int t, input int chg_cyc, input int spur_cyc,
                           input int abort_cyc);
    wr_a.delete(); wr_d.delete(); rd_a.delete();
    last_wr = -1; done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1;
    busy_cnt = 0; thr_bad = 0; overlap = 0;
    start = 1'b1;
    thr   = 8'(t);
    step();
    start = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      if (n == abort_cyc) begin
        rstn = 1'b0;
        step();
        break;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first < 0) busy_first = n;
        busy_last = n;
        if (int'(eng_thr) != t) thr_bad++;
      end
      if (rd_en) rd_a.push_back(int'(rd_addr));
      if (wr_en) begin
        wr_a.push_back(int'(wr_addr));
        wr_d.push_back(int'(wr_data));
        last_wr = n;
      end
      if (done) begin
        done_cnt++;
        done_cyc = n;
        if (wr_en) overlap++;
        break;
      end
      start = (n == spur_cyc);
      if (n == chg_cyc) thr = 8'd200;
      if (n == spur_cyc) thr = 8'd99;
      step();
    end
    start = 1'b0;
  endtask

  task automatic verify_frame(input string tag, input int t);
    check_val({tag, "_wr_count"}, wr_a.size(), (SH - 2) * (SW - 2));
    for (int i = 0; i < wr_a.size(); i++) begin
      check_val($sformatf("%s_wr_addr%0d", tag, i), wr_a[i], i);
      check_val($sformatf("%s_wr_data%0d", tag, i), wr_d[i],
                ref_bit(i / (SW - 2), i % (SW - 2), t));
    end
    check_val({tag, "_last_wr"}, last_wr, 40);
    check_val({tag, "_done_cyc"}, done_cyc, 41);
    check_val({tag, "_done_cnt"}, done_cnt, 1);
    check_val({tag, "_busy_first"}, busy_first, 1);
    check_val({tag, "_busy_last"}, busy_last, 40);
    check_val({tag, "_busy_cnt"}, busy_cnt, 40);
    check_val({tag, "_thr_held"}, thr_bad, 0);
    check_val({tag, "_done_wr"}, overlap, 0);
    // done is a single-cycle pulse
    step();
    check_val({tag, "_done_fall"}, int'(done), 0);
    check_val({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int snap, idle_bad, b_cnt, b_bad, b_done_cyc, b_last;
    rstn = 1'b0; start = 1'b0; thr = 8'd0; spur_rdy = 1'b0; b_start = 1'b0;
    step(); step(); step();
    check_reset("por");
    rstn = 1'b1;
    step();
    check_val("idle_no_start", int'(busy), 0);

    // Basic frame and read ordering.
    run_frame(50, -1, -1, -1);
    check_val("basic_rd_count", rd_a.size(), 30);
    for (int i = 0; i < rd_a.size(); i++) begin
      check_val($sformatf("rd_order%0d", i), rd_a[i],
                ((i / 15) + (i % 15) % 3) * SW + (i % 15) / 3);
    end
    verify_frame("basic", 50);

    // Threshold capture with mid-frame thr change and a spurious start.
    run_frame(30, 10, 15, -1);
    verify_frame("thr", 30);
    check_val("thr_after", int'(eng_thr), 30);

    // Stray engine result while idle.
    snap = tot_wr;
    spur_rdy = 1'b1;
    #1;
    check_val("spur_rdy_wr_en", int'(wr_en), 0);
    step();
    spur_rdy = 1'b0;
    step();
    check_val("spur_rdy_count", tot_wr - snap, 0);
    check_val("spur_rdy_busy", int'(busy), 0);

    // Reset during band 1 load, then a clean frame.
    run_frame(50, -1, -1, 25);
    check_reset("abort");
    rstn = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy || rd_en || eng_rstn) idle_bad++;
    end
    check_val("abort_no_resume", idle_bad, 0);
    run_frame(70, -1, -1, -1);
    verify_frame("after_abort", 70);

    // Larger geometry: write count, address sequence and completion time.
    b_cnt = 0; b_bad = 0; b_done_cyc = -1; b_last = -1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int n = 1; n <= 600; n++) begin
      if (b_wr_en) begin
        if (int'(b_wr_addr) != b_cnt) b_bad++;
        b_cnt++;
        b_last = n;
      end
      if (b_done) begin
        b_done_cyc = n;
        break;
      end
      step();
    end
    check_val("big_wr_count", b_cnt, (BH - 2) * (BW - 2));
    check_val("big_wr_addr_seq", b_bad, 0);
    check_val("big_last_wr", b_last, (BH - 2) * 4 * BW);
    check_val("big_done_cyc", b_done_cyc, (BH - 2) * 4 * BW + 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_frame_ctrl.md
SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

Interface
REQ-001 The block SHALL have these parameters:
- H, default 200, image height in pixels (H >= 3).
- W, default 160, image width in pixels (W >= 3).
- AW, default 16, address width (H*W <= 2^AW).

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rstn  in  1  reset; synchronous, active-low.
- start  in  1  frame start request; sampled only in IDLE.
- thr  in  8  edge threshold; captured on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame completion.
- rd_en  out  1  pixel memory read strobe.
- rd_addr  out  AW  pixel address, row*W + col.
- rd_data  in  8  pixel data, valid the cycle after rd_en.
- eng_rstn  out  1  synchronous active-low reset to the sobel engine.
- eng_data  out  8  pixel to the engine; a direct wire from rd_data.
- eng_thr  out  8  threshold to the engine; holds the captured thr.
- eng_ready  in  1  engine result-valid pulse.
- eng_bit  in  1  engine edge result.
- wr_en  out  1  edge memory write strobe.
- wr_addr  out  AW  edge address, r*(W-2) + k.
- wr_data  out  1  edge bit.

Function
REQ-003 The engine contract SHALL be:
- After one cycle with eng_rstn=0, the engine consumes eng_data on 9 consecutive cycles (column-major: rows r, r+1, r+2 of col 0, then col 1, then col 2).
- It then has one compute (gap) cycle in which eng_data is ignored.
- It then repeats: 3 consume cycles (rows r..r+2 of the next column) followed by 1 gap.
- eng_ready pulses in the cycle after each gap.

REQ-004 The FSM SHALL have these states:
- IDLE
- BAND_RST (1 cycle)
- LOAD (9 cycles)
- GAP (1 cycle)
- SHIFT (3 cycles)
- DRAIN (1 cycle)
- FIN (1 cycle)

REQ-005 IDLE SHALL behave as follows:
- eng_rstn=0 and busy=0.
- start=1 captures thr into eng_thr, sets band r=0, asserts busy, and goes to BAND_RST.

REQ-006 Transitions SHALL be:
- BAND_RST -> LOAD.
- LOAD -> GAP after 9 cycles.
- GAP -> SHIFT while unfed columns remain in the band, else -> DRAIN.
- SHIFT -> GAP after 3 cycles.
- DRAIN -> BAND_RST with r+1 if r < H-3, else -> FIN.
- FIN -> IDLE.

REQ-007 eng_rstn SHALL be 0 in IDLE and BAND_RST and 1 in all other states.

REQ-008 Reads SHALL be one cycle ahead of consumption:
- In the cycle preceding each engine consume cycle, rd_en=1 with the address of the pixel consumed next.
- rd_en=0 in the cycle preceding each GAP and DRAIN cycle, and in IDLE and FIN.

REQ-009 Read order within band r SHALL be: column c from 0 to W-1, and within each column rows r, r+1, r+2.

REQ-010 Band length SHALL be exactly 4*W cycles, BAND_RST through DRAIN inclusive.

REQ-011 Every cycle with eng_ready=1 and busy=1 SHALL produce a write:
- wr_en=1 and wr_data=eng_bit in that same cycle.
- wr_addr = r*(W-2)+k, where k is the per-band result index 0..W-3.
- k clears at BAND_RST.

REQ-012 Result k of band r SHALL be the edge bit for image pixel (r+1, k+1); border pixels are not written.

REQ-013 eng_ready while busy=0 SHALL be ignored (no write).

REQ-014 FIN SHALL assert done=1 for one cycle and deassert busy in that same cycle; done shall never coincide with wr_en.

REQ-015 start asserted while busy=1 SHALL be ignored and shall not change eng_thr.

REQ-016 thr changes during a frame SHALL NOT affect eng_thr.

REQ-017 All counters (r, column, row-in-column, k) SHALL be sized for H, W and shall never wrap within a frame.

Reset
REQ-018 rstn=0 at any rising edge SHALL force the following on the next cycle, including mid-frame:
- State IDLE.
- busy=0, done=0, rd_en=0, wr_en=0.
- eng_rstn=0, eng_thr=0.
- rd_addr=0, wr_addr=0, wr_data=0.
- All counters cleared.

REQ-019 After reset release, the block SHALL remain in IDLE until start=1; an aborted frame is not resumed.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Basic frame (H=4, W=5, thr=50, start at cycle 0) -> 6 writes to addresses 0..5, last write at cycle 40, done pulse at cycle 41, busy high in cycles 1..40.
- Read order (H=4, W=5) -> band 0 addresses 0,5,10,1,6,11,2,7,12,3,8,13,4,9,14; band 1 the same +5.
- Default size (H=200, W=160) -> 198*158 = 31284 writes, done exactly 126721 cycles after the start cycle.
- Threshold capture (start with thr=30, then thr=200 mid-frame, engine model compares Gx+Gy > eng_thr) -> results match a reference using 30; eng_thr=30 throughout.
- Reset mid-frame (rstn=0 during band 1 LOAD) -> next cycle all outputs at reset values; a new start yields a complete correct frame.
- Spurious stimulus (start pulsed while busy, eng_ready pulsed while idle) -> no restart, no extra writes, write count unchanged.
